// File: rtl/pipe_stall_ctrl.sv
// IF-stage PC / IF-ID register control with stall hold, branch redirect and stall-limit watchdog.
// Optional total stall counter on StallCount is built only when PIPE_STALL_CNT_EN is defined.
module pipe_stall_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned STALL_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        BranchBubble,
   input  logic        LoadBubble,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic [31:0] if_Instr,
   output logic [31:0] pc,
   output logic [31:0] id_Instr,
   output logic [31:0] id_PCplus4,
   output logic        id_Valid,
   output logic        IdExFlush,
   output logic        StallErr,
   output logic [31:0] StallCount
);

   localparam int unsigned CW = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);

   logic          stall;
   logic [31:0]   pc_plus4;
   logic [CW-1:0] consec_stalls;

   assign stall     = BranchBubble | LoadBubble;
   assign IdExFlush = stall;
   assign pc_plus4  = pc + 32'd4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         id_Instr   <= '0;
         id_PCplus4 <= '0;
         id_Valid   <= 1'b0;
      end else if (!stall) begin
         id_PCplus4 <= pc_plus4;
         if (BranchTaken) begin
            // Taken branch squashes the wrong-path fetch into a bubble.
            pc       <= BranchTarget;
            id_Instr <= '0;
            id_Valid <= 1'b0;
         end else begin
            pc       <= pc_plus4;
            id_Instr <= if_Instr;
            id_Valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         consec_stalls <= '0;
         StallErr      <= 1'b0;
      end else if (stall) begin
         if (consec_stalls != LIMIT) consec_stalls <= consec_stalls + 1'b1;
         // Fires on the edge the counter lands on the limit; sticky thereafter.
         if (consec_stalls >= LIMIT - 1'b1) StallErr <= 1'b1;
      end else begin
         consec_stalls <= '0;
      end
   end

`ifdef PIPE_STALL_CNT_EN
   logic [31:0] stall_total;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_total <= '0;
      end else if (stall && (stall_total != '1)) begin
         stall_total <= stall_total + 32'd1;
      end
   end

   assign StallCount = stall_total;
`else
   assign StallCount = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch/stall rules.
module tb_pipe_stall_ctrl;

   localparam int unsigned LIMIT = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        BranchBubble = 1'b0;
   logic        LoadBubble = 1'b0;
   logic        BranchTaken = 1'b0;
   logic [31:0] BranchTarget = '0;
   logic [31:0] if_Instr = '0;
   logic [31:0] pc, id_Instr, id_PCplus4, StallCount;
   logic        id_Valid, IdExFlush, StallErr;

   int errors = 0;
   int checks = 0;

   // Behavioural model state
   logic [31:0]     m_pc, m_instr, m_p4;
   logic            m_valid, m_err;
   int unsigned     m_consec;
   longint unsigned m_cnt;

   pipe_stall_ctrl #(.RESET_PC(32'h0000_0000), .STALL_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .BranchBubble(BranchBubble), .LoadBubble(LoadBubble),
      .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .if_Instr(if_Instr), .pc(pc), .id_Instr(id_Instr),
      .id_PCplus4(id_PCplus4), .id_Valid(id_Valid),
      .IdExFlush(IdExFlush), .StallErr(StallErr), .StallCount(StallCount)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] exp_count(input int unsigned n);
`ifdef PIPE_STALL_CNT_EN
      return n;
`else
      return (n == 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   function automatic logic [31:0] model_count();
`ifdef PIPE_STALL_CNT_EN
      return m_cnt[31:0];
`else
      return 32'd0;
`endif
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_instr = '0; m_p4 = '0; m_valid = 1'b0;
      m_err = 1'b0; m_consec = 0; m_cnt = 0;
   endtask

   task automatic drive(input logic bb, input logic lb, input logic bt,
                        input logic [31:0] tgt, input logic [31:0] instr);
      BranchBubble = bb; LoadBubble = lb; BranchTaken = bt;
      BranchTarget = tgt; if_Instr = instr;
   endtask

   // Advance one rising edge and apply the same edge to the model.
   task automatic tick();
      @(posedge clk);
      if (BranchBubble || LoadBubble) begin
         if (m_consec < LIMIT) m_consec++;
         if (m_consec == LIMIT) m_err = 1'b1;
         if (m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt++;
      end else begin
         m_consec = 0;
         m_p4 = m_pc + 32'd4;
         if (BranchTaken) begin
            m_pc = BranchTarget; m_instr = '0; m_valid = 1'b0;
         end else begin
            m_pc = m_pc + 32'd4; m_instr = if_Instr; m_valid = 1'b1;
         end
      end
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 32'h0, 32'h0);
      apply_reset();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
      checks++; if (id_Instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", id_Instr); end
      checks++; if (id_PCplus4 !== 32'h0) begin errors++; $display("FAIL reset_p4: got %h want 0", id_PCplus4); end
      checks++; if (id_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", id_Valid); end
      checks++; if (StallErr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", StallErr); end
      checks++; if (StallCount !== 32'h0) begin errors++; $display("FAIL reset_count: got %h want 0", StallCount); end
   endtask

   task automatic test_free_run();
      drive(0, 0, 0, 32'h0, 32'h1111_1111);
      repeat (3) tick();
      checks++; if (pc !== 32'h0C) begin errors++; $display("FAIL free_pc: got %h want 0000000c", pc); end
      checks++; if (id_Instr !== 32'h1111_1111) begin errors++; $display("FAIL free_instr: got %h want 11111111", id_Instr); end
      checks++; if (id_PCplus4 !== 32'h0C) begin errors++; $display("FAIL free_p4: got %h want 0000000c", id_PCplus4); end
      checks++; if (id_Valid !== 1'b1) begin errors++; $display("FAIL free_valid: got %b want 1", id_Valid); end
      checks++; if (IdExFlush !== 1'b0) begin errors++; $display("FAIL free_flush: got %b want 0", IdExFlush); end
   endtask

   task automatic test_single_stall();
      tick();
      checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_pre_pc: got %h want 00000010", pc); end
      drive(1, 0, 0, 32'h0, 32'hAAAA_0001);
      #1;
      checks++; if (IdExFlush !== 1'b1) begin errors++; $display("FAIL stall_flush: got %b want 1", IdExFlush); end
      tick();
      checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_hold_pc: got %h want 00000010", pc); end
      checks++; if (id_Instr !== 32'h1111_1111) begin errors++; $display("FAIL stall_hold_instr: got %h want 11111111", id_Instr); end
      checks++; if (id_PCplus4 !== 32'h10) begin errors++; $display("FAIL stall_hold_p4: got %h want 00000010", id_PCplus4); end
      checks++; if (id_Valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid: got %b want 1", id_Valid); end
      drive(0, 0, 0, 32'h0, 32'h2222_2222);
      #1;
      checks++; if (IdExFlush !== 1'b0) begin errors++; $display("FAIL stall_unflush: got %b want 0", IdExFlush); end
      tick();
      checks++; if (pc !== 32'h14) begin errors++; $display("FAIL stall_resume_pc: got %h want 00000014", pc); end
      checks++; if (id_Instr !== 32'h2222_2222) begin errors++; $display("FAIL stall_resume_instr: got %h want 22222222", id_Instr); end
      checks++; if (StallCount !== exp_count(1)) begin errors++; $display("FAIL stall_count: got %0d want %0d", StallCount, exp_count(1)); end
   endtask

   task automatic test_branch();
      drive(0, 0, 0, 32'h0, 32'h3333_0000);
      repeat (3) tick();
      checks++; if (pc !== 32'h20) begin errors++; $display("FAIL br_pre_pc: got %h want 00000020", pc); end
      drive(0, 0, 1, 32'h100, 32'h3333_3333);
      tick();
      checks++; if (pc !== 32'h100) begin errors++; $display("FAIL br_pc: got %h want 00000100", pc); end
      checks++; if (id_Instr !== 32'h0) begin errors++; $display("FAIL br_instr: got %h want 0", id_Instr); end
      checks++; if (id_Valid !== 1'b0) begin errors++; $display("FAIL br_valid: got %b want 0", id_Valid); end
      checks++; if (id_PCplus4 !== 32'h24) begin errors++; $display("FAIL br_p4: got %h want 00000024", id_PCplus4); end
   endtask

   task automatic test_priority();
      drive(0, 1, 1, 32'h200, 32'h4444_4444);
      #1;
      checks++; if (IdExFlush !== 1'b1) begin errors++; $display("FAIL prio_flush: got %b want 1", IdExFlush); end
      tick();
      checks++; if (pc !== 32'h100) begin errors++; $display("FAIL prio_hold_pc: got %h want 00000100", pc); end
      checks++; if (id_PCplus4 !== 32'h24) begin errors++; $display("FAIL prio_hold_p4: got %h want 00000024", id_PCplus4); end
      checks++; if (id_Valid !== 1'b0) begin errors++; $display("FAIL prio_hold_valid: got %b want 0", id_Valid); end
      drive(0, 0, 1, 32'h200, 32'h4444_4444);
      tick();
      checks++; if (pc !== 32'h200) begin errors++; $display("FAIL prio_redirect_pc: got %h want 00000200", pc); end
      checks++; if (id_PCplus4 !== 32'h104) begin errors++; $display("FAIL prio_redirect_p4: got %h want 00000104", id_PCplus4); end
   endtask

   task automatic test_stall_limit();
      drive(0, 0, 0, 32'h0, 32'h0);
      apply_reset();
      drive(1, 0, 0, 32'h0, 32'h0);
      repeat (LIMIT - 1) tick();
      checks++; if (StallErr !== 1'b0) begin errors++; $display("FAIL limit_7: got %b want 0", StallErr); end
      drive(0, 0, 0, 32'h0, 32'h0);
      tick();
      checks++; if (StallErr !== 1'b0) begin errors++; $display("FAIL limit_clear: got %b want 0", StallErr); end
      drive(0, 1, 0, 32'h0, 32'h0);
      repeat (LIMIT - 1) tick();
      checks++; if (StallErr !== 1'b0) begin errors++; $display("FAIL limit_7b: got %b want 0", StallErr); end
      tick();
      checks++; if (StallErr !== 1'b1) begin errors++; $display("FAIL limit_8: got %b want 1", StallErr); end
      drive(1, 1, 0, 32'h0, 32'h0);
      tick();
      checks++; if (StallCount !== exp_count(2 * LIMIT)) begin errors++; $display("FAIL limit_count: got %0d want %0d", StallCount, exp_count(2 * LIMIT)); end
      drive(0, 0, 0, 32'h0, 32'h0);
      tick();
      checks++; if (StallErr !== 1'b1) begin errors++; $display("FAIL limit_sticky: got %b want 1", StallErr); end
   endtask

   task automatic test_wrap();
      drive(0, 0, 1, 32'hFFFF_FFFC, 32'h0);
      tick();
      checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre_pc: got %h want fffffffc", pc); end
      drive(0, 0, 0, 32'h0, 32'h5555_5555);
      tick();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", pc); end
      checks++; if (id_PCplus4 !== 32'h0) begin errors++; $display("FAIL wrap_p4: got %h want 0", id_PCplus4); end
   endtask

   task automatic test_async_reset();
      drive(0, 0, 0, 32'h0, 32'h7777_7777);
      repeat (2) tick();
      drive(1, 0, 0, 32'h0, 32'h7777_7777);
      tick();
      checks++; if (pc !== 32'h8) begin errors++; $display("FAIL ar_pre_pc: got %h want 00000008", pc); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL ar_pc: got %h want 0", pc); end
      checks++; if (id_Instr !== 32'h0) begin errors++; $display("FAIL ar_instr: got %h want 0", id_Instr); end
      checks++; if (id_Valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", id_Valid); end
      checks++; if (StallErr !== 1'b0) begin errors++; $display("FAIL ar_err: got %b want 0", StallErr); end
      checks++; if (StallCount !== 32'h0) begin errors++; $display("FAIL ar_count: got %h want 0", StallCount); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL ar_stall_pc: got %h want 0", pc); end
      drive(0, 0, 0, 32'h0, 32'h6666_6666);
      tick();
      checks++; if (pc !== 32'h4) begin errors++; $display("FAIL ar_run_pc: got %h want 00000004", pc); end
      checks++; if (id_Instr !== 32'h6666_6666) begin errors++; $display("FAIL ar_run_instr: got %h want 66666666", id_Instr); end
      checks++; if (id_Valid !== 1'b1) begin errors++; $display("FAIL ar_run_valid: got %b want 1", id_Valid); end
   endtask

   task automatic test_random();
      logic bb, lb, bt;
      logic [31:0] tgt, instr;
      int unsigned prob, sel;
      for (int seg = 0; seg < 24; seg++) begin
         if (seg % 6 == 0) begin
            drive(0, 0, 0, 32'h0, 32'h0);
            apply_reset();
         end
         prob = ($urandom_range(0, 1) == 1) ? 90 : 25;
         for (int c = 0; c < 20; c++) begin
            bb = 1'b0; lb = 1'b0;
            if ($urandom_range(0, 99) < prob) begin
               sel = $urandom_range(1, 3);
               bb = sel[0]; lb = sel[1];
            end
            bt = ($urandom_range(0, 3) == 0);
            tgt = $urandom() & 32'hFFFF_FFFC;
            instr = $urandom();
            drive(bb, lb, bt, tgt, instr);
            #1;
            checks++; if (IdExFlush !== (bb | lb)) begin errors++; $display("FAIL rnd_flush: got %b want %b", IdExFlush, bb | lb); end
            tick();
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc: got %h want %h", pc, m_pc); end
            checks++; if (id_Instr !== m_instr) begin errors++; $display("FAIL rnd_instr: got %h want %h", id_Instr, m_instr); end
            checks++; if (id_PCplus4 !== m_p4) begin errors++; $display("FAIL rnd_p4: got %h want %h", id_PCplus4, m_p4); end
            checks++; if (id_Valid !== m_valid) begin errors++; $display("FAIL rnd_valid: got %b want %b", id_Valid, m_valid); end
            checks++; if (StallErr !== m_err) begin errors++; $display("FAIL rnd_err: got %b want %b", StallErr, m_err); end
            checks++; if (StallCount !== model_count()) begin errors++; $display("FAIL rnd_count: got %0d want %0d", StallCount, model_count()); end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_free_run();
      test_single_stall();
      test_branch();
      test_priority();
      test_stall_limit();
      test_wrap();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 The block SHALL have parameter STALL_LIMIT, default 8: consecutive stall cycles tolerated before StallErr is set.
REQ-003 The block SHALL have port clk  input  1: the single clock, rising-edge.
REQ-004 The block SHALL have port rst_n  input  1: asynchronous reset, active-low.
REQ-005 The block SHALL have port BranchBubble  input  1: branch-operand hazard stall request from the ID-stage branch hazard detector.
REQ-006 The block SHALL have port LoadBubble  input  1: load-use stall request.
REQ-007 The block SHALL have port BranchTaken  input  1: branch resolved taken in ID this cycle.
REQ-008 The block SHALL have port BranchTarget  input  32: taken-branch target address.
REQ-009 The block SHALL have port if_Instr  input  32: instruction fetched at pc.
REQ-010 The block SHALL have port pc  output  32: registered fetch address.
REQ-011 The block SHALL have port id_Instr  output  32: registered IF/ID instruction.
REQ-012 The block SHALL have port id_PCplus4  output  32: registered IF/ID pc+4.
REQ-013 The block SHALL have port id_Valid  output  1: registered, IF/ID holds a real instruction.
REQ-014 The block SHALL have port IdExFlush  output  1: combinational, zero the ID/EX control fields this cycle.
REQ-015 The block SHALL have port StallErr  output  1: registered sticky stall-limit error.
REQ-016 The block SHALL have port StallCount  output  32: total stall cycles, per REQ-030.

Function
REQ-017 The block SHALL define stall = BranchBubble OR LoadBubble, combinationally.
REQ-018 The block SHALL drive IdExFlush = stall with zero latency.
REQ-019 On a rising edge with stall=1, the block SHALL hold pc, id_Instr, id_PCplus4 and id_Valid unchanged.
REQ-020 On a rising edge with stall=0 and BranchTaken=1, the block SHALL load pc<=BranchTarget, id_Instr<=32'h0000_0000, id_Valid<=0, and id_PCplus4<=pc+4.
REQ-021 On a rising edge with stall=0 and BranchTaken=0, the block SHALL load pc<=pc+4, id_Instr<=if_Instr, id_PCplus4<=pc+4, and id_Valid<=1.
REQ-022 The block SHALL give stall priority over BranchTaken: BranchTaken is ignored in any cycle with stall=1.
REQ-023 The block SHALL compute pc+4 modulo 2^32 (32'hFFFF_FFFC+4 = 32'h0000_0000, no error).
REQ-024 The block SHALL keep a consecutive-stall counter that increments on each stalled edge, saturates at STALL_LIMIT, and clears on any non-stalled edge.
REQ-025 The block SHALL set StallErr on the edge where the consecutive-stall counter reaches STALL_LIMIT; StallErr SHALL remain set until reset.
REQ-026 The block SHALL treat simultaneous BranchBubble and LoadBubble as one stall cycle, counted once.

Reset
REQ-027 While rst_n=0, the block SHALL immediately force pc=RESET_PC, id_Instr=0, id_PCplus4=0, id_Valid=0, StallErr=0, the consecutive-stall counter to 0, and StallCount to 0, regardless of clk.
REQ-028 An assertion of rst_n mid-stall SHALL discard the held IF/ID contents; the first edge after rst_n rises SHALL follow REQ-019 to REQ-021 from the reset state.

Configuration
REQ-029 The block SHALL have exactly one compile-time feature: macro PIPE_STALL_CNT_EN.
REQ-030 With PIPE_STALL_CNT_EN defined, StallCount SHALL increment by 1 on every stalled edge and saturate at 32'hFFFF_FFFF.
REQ-031 Without PIPE_STALL_CNT_EN, StallCount SHALL be a constant 0 and no counter register SHALL be built; all other behaviour SHALL be identical.

Verification
REQ-032 Reset then free-run: release rst_n with if_Instr=32'h1111_1111 -> after 3 edges, pc=0x0C, id_Instr=32'h1111_1111, id_PCplus4=0x0C, id_Valid=1, IdExFlush=0.
REQ-033 Single stall: pc=0x10, BranchBubble=1 for 1 cycle -> IdExFlush=1 in that cycle, pc stays 0x10 and IF/ID unchanged across the edge, pc=0x14 on the next edge; StallCount=1 with PIPE_STALL_CNT_EN defined.
REQ-034 Taken branch: pc=0x20, BranchTaken=1, BranchTarget=0x100, no stall -> next edge pc=0x100, id_Instr=0, id_Valid=0.
REQ-035 Stall priority: BranchTaken=1 and LoadBubble=1 in the same cycle -> pc and IF/ID held; after the stall drops with BranchTaken still 1, pc=BranchTarget on the following edge.
REQ-036 Stall limit: stall held for 8 edges with STALL_LIMIT=8 -> StallErr=1 after the 8th edge and still 1 after the stall drops; 7 edges -> StallErr=0.
REQ-037 Wrap and async reset: pc=32'hFFFF_FFFC with no stall -> pc=0 after the next edge; drop rst_n between edges -> pc=RESET_PC before the next clk edge.
